// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data bits LSB first, odd parity, stop, ack.
// Optional frame watchdog is compiled in when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       k_clock,
  input  logic       k_data,
  output logic       k_clock_oe,
  output logic       k_data_oe,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    BITS,
    STOP,
    ACK,
    RELEASE
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       kclk_sync_reg, kdat_sync_reg;
  logic             kclk_prev_reg;
  logic [8:0]       frame_reg, frame_next;
  logic [3:0]       bit_cnt_reg, bit_cnt_next;
  logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
  logic             tx_done_reg, tx_done_next;
  logic             tx_err_reg, tx_err_next;
  logic             kclk_s, kdat_s, kclk_fall, inh_last, timeout;

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  assign kclk_s    = kclk_sync_reg[1];
  assign kdat_s    = kdat_sync_reg[1];
  assign kclk_fall = kclk_prev_reg & ~kclk_s;
  assign inh_last  = (inh_cnt_reg == INH_W'(INHIBIT_CYCLES - 1));
  assign tx_done   = tx_done_reg;
  assign tx_err    = tx_err_reg;

  // Idle PS/2 lines are high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_sync_reg <= 2'b11;
      kdat_sync_reg <= 2'b11;
      kclk_prev_reg <= 1'b1;
    end else begin
      kclk_sync_reg <= {kclk_sync_reg[0], k_clock};
      kdat_sync_reg <= {kdat_sync_reg[0], k_data};
      kclk_prev_reg <= kclk_s;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_reg;
  logic            wd_at_limit;

  assign wd_at_limit = (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));
  // RELEASE is already the recovery state; firing there would give a second error pulse.
  assign timeout = wd_at_limit && (state_reg != IDLE) && (state_reg != RELEASE);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      wd_cnt_reg <= '0;
    end else if (!wd_at_limit) begin
      wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      frame_reg   <= '0;
      bit_cnt_reg <= '0;
      inh_cnt_reg <= '0;
      tx_done_reg <= 1'b0;
      tx_err_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      frame_reg   <= frame_next;
      bit_cnt_reg <= bit_cnt_next;
      inh_cnt_reg <= inh_cnt_next;
      tx_done_reg <= tx_done_next;
      tx_err_reg  <= tx_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    frame_next   = frame_reg;
    bit_cnt_next = bit_cnt_reg;
    inh_cnt_next = inh_cnt_reg;
    tx_done_next = 1'b0;
    tx_err_next  = 1'b0;
    tx_ready     = 1'b0;
    k_clock_oe   = 1'b0;
    k_data_oe    = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          frame_next   = {~^tx_data, tx_data};
          bit_cnt_next = '0;
          inh_cnt_next = '0;
          state_next   = INHIBIT;
        end
      end

      INHIBIT: begin
        k_clock_oe = 1'b1;
        if (inh_last) begin
          k_data_oe  = 1'b1;
          state_next = START;
        end else begin
          inh_cnt_next = inh_cnt_reg + INH_W'(1);
        end
      end

      START: begin
        k_data_oe = 1'b1;
        if (kclk_fall) begin
          state_next = BITS;
        end
      end

      // Index 0..7 are data bits, index 8 is parity; open-drain drives the inverse.
      BITS: begin
        k_data_oe = ~frame_reg[bit_cnt_reg];
        if (kclk_fall) begin
          if (bit_cnt_reg == 4'd8) begin
            state_next = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
      end

      STOP: begin
        if (kclk_fall) begin
          if (!kdat_s) begin
            state_next = ACK;
          end else begin
            tx_err_next = 1'b1;
            state_next  = RELEASE;
          end
        end
      end

      ACK: begin
        if (kclk_s && kdat_s) begin
          tx_done_next = 1'b1;
          state_next   = IDLE;
        end
      end

      RELEASE: begin
        if (kclk_s && kdat_s) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    // Watchdog overrides everything, including a done pulse from ACK in the same cycle.
    if (timeout) begin
      state_next   = RELEASE;
      tx_done_next = 1'b0;
      tx_err_next  = 1'b1;
      k_clock_oe   = 1'b0;
      k_data_oe    = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: table of frames against an open-drain device model,
// plus hand-written sequences for mid-frame reset and a silent device.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int TO   = 3000;
  localparam int HALF = 8;

  logic       sys_clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  wire logic  k_clock;
  wire logic  k_data;
  logic       k_clock_oe;
  logic       k_data_oe;
  logic       tx_done;
  logic       tx_err;
  logic       dev_clk_low;
  logic       dev_data_low;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int cyc = 0;
  int t_accept = 0;

  assign k_clock = ~(k_clock_oe | dev_clk_low);
  assign k_data  = ~(k_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .k_clock    (k_clock),
    .k_data     (k_data),
    .k_clock_oe (k_clock_oe),
    .k_data_oe  (k_data_oe),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  typedef struct {
    logic [7:0]  data;
    logic        ack_good;
    logic [10:0] exp_bits;  // bit k = line value before falling edge k+1
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Request a byte and measure the inhibit phase; tx_valid is held during it with other data.
  task automatic send(input logic [7:0] d, input int idx);
    int n_clk;
    int rise_at;
    int waited;
    @(negedge sys_clk);
    tx_data  = d;
    tx_valid = 1'b1;
    waited   = 0;
    while (!tx_ready && waited < 20) begin
      @(negedge sys_clk);
      waited++;
    end
    check($sformatf("v%0d_ready_before", idx), 32'(tx_ready), 32'd1);
    @(negedge sys_clk);
    t_accept = cyc;
    tx_data  = ~d;
    n_clk    = 0;
    rise_at  = 0;
    while (k_clock_oe && n_clk < INH + 10) begin
      n_clk++;
      if (k_data_oe && rise_at == 0) rise_at = n_clk;
      @(negedge sys_clk);
    end
    tx_valid = 1'b0;
    check($sformatf("v%0d_inhibit_len", idx), 32'(n_clk), 32'(INH));
    check($sformatf("v%0d_data_rise", idx), 32'(rise_at), 32'(INH));
    check($sformatf("v%0d_start_oe", idx), {30'd0, k_clock_oe, k_data_oe}, 32'b01);
    $display("send v%0d data=%02h inhibit=%0d data_rise=%0d", idx, d, n_clk, rise_at);
  endtask

  task automatic run_device(input int n_edges, input logic ack_good, output logic [10:0] bits);
    bits = '0;
    for (int k = 0; k < n_edges; k++) begin
      wait_cycles(HALF);
      bits[k] = k_data;
      if (k == 10 && ack_good) begin
        dev_data_low = 1'b1;
        wait_cycles(4);
      end
      dev_clk_low = 1'b1;
      wait_cycles(HALF);
      dev_clk_low = 1'b0;
    end
    wait_cycles(4);
    dev_data_low = 1'b0;
  endtask

  initial begin
    logic [10:0] bits;
    int d0, e0, waited;

    vecs[0] = '{8'hED, 1'b1, 11'h7DA, 1, 0};
    vecs[1] = '{8'h01, 1'b1, 11'h402, 1, 0};
    vecs[2] = '{8'hA5, 1'b0, 11'h74A, 0, 1};
    vecs[3] = '{8'h00, 1'b1, 11'h600, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 11'h7FE, 1, 0};
    vecs[5] = '{8'h80, 1'b0, 11'h500, 0, 1};

    rst_n        = 1'b0;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    wait_cycles(3);
    check("reset_oe", {30'd0, k_clock_oe, k_data_oe}, 32'd0);
    check("reset_ready", 32'(tx_ready), 32'd1);
    check("reset_pulses", {30'd0, tx_done, tx_err}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(3);
    check("idle_ready", 32'(tx_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send(vecs[i].data, i);
      run_device(11, vecs[i].ack_good, bits);
      waited = 0;
      while (!tx_ready && waited < 50) begin
        @(negedge sys_clk);
        waited++;
      end
      wait_cycles(2);
      check($sformatf("v%0d_line_bits", i), 32'(bits), 32'(vecs[i].exp_bits));
      check($sformatf("v%0d_ready_after", i), 32'(tx_ready), 32'd1);
      check($sformatf("v%0d_done_pulses", i), 32'(done_cnt - d0), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_err_pulses", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      $display("frame v%0d data=%02h bits=%03h done=%0d err=%0d",
               i, vecs[i].data, bits, done_cnt - d0, err_cnt - e0);
    end

    // Reset after the 5th falling edge: host is driving bit4 of 8'h0F (a 0, so data pulled low).
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h0F, 6);
    run_device(5, 1'b0, bits);
    check("midreset_pre_data_oe", 32'(k_data_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_oe", {30'd0, k_clock_oe, k_data_oe}, 32'd0);
    check("midreset_ready", 32'(tx_ready), 32'd1);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(20);
    check("midreset_ready_after", 32'(tx_ready), 32'd1);
    check("midreset_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    $display("midreset done=%0d err=%0d", done_cnt - d0, err_cnt - e0);

    // Device never clocks after the inhibit phase.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h55, 7);
`ifdef PS2_TX_TIMEOUT_EN
    waited = 0;
    while (!tx_err && waited < TO + 100) begin
      @(negedge sys_clk);
      waited++;
    end
    check("timeout_err", 32'(tx_err), 32'd1);
    check("timeout_at", 32'(cyc - t_accept), 32'(TO));
    check("timeout_released", {30'd0, k_clock_oe, k_data_oe}, 32'd0);
    waited = 0;
    while (!tx_ready && waited < 20) begin
      @(negedge sys_clk);
      waited++;
    end
    wait_cycles(2);
    check("timeout_ready", 32'(tx_ready), 32'd1);
    check("timeout_err_once", 32'(err_cnt - e0), 32'd1);
    $display("silent timeout err=%0d done=%0d", err_cnt - e0, done_cnt - d0);
`else
    wait_cycles(TO + 100);
    check("silent_in_start", {30'd0, k_clock_oe, k_data_oe}, 32'b01);
    check("silent_not_ready", 32'(tx_ready), 32'd0);
    check("silent_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    $display("silent stuck_in_start oe=%0b%0b", k_clock_oe, k_data_oe);
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);
`endif

    check("never_done_and_err", 32'(both_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, 6000, sys_clk cycles k_clock is held low before the start bit (120 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, 1000000, watchdog limit in sys_clk cycles for one whole frame (20 ms at 50 MHz).
REQ-003 sys_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 tx_data  input  8  command byte to send to the keyboard (e.g. 8'hED LED set).
REQ-006 tx_valid  input  1  request to send tx_data.
REQ-007 tx_ready  output  1  high only in IDLE; a byte is accepted on the cycle where tx_valid and tx_ready are both high.
REQ-008 k_clock  input  1  PS/2 clock line as seen on the pin.
REQ-009 k_data  input  1  PS/2 data line as seen on the pin.
REQ-010 k_clock_oe  output  1  1 = pull PS/2 clock low, 0 = release (open-drain).
REQ-011 k_data_oe  output  1  1 = pull PS/2 data low, 0 = release (open-drain).
REQ-012 tx_done  output  1  one-cycle pulse when the frame completes and the device acknowledges.
REQ-013 tx_err  output  1  one-cycle pulse on missing acknowledge or timeout.

Function
REQ-014 k_clock and k_data SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be flagged when the previous synchronized clock sample is 1 and the current sample is 0.
REQ-015 States SHALL be IDLE, INHIBIT, START, BITS, STOP, ACK, RELEASE.
REQ-016 IDLE: both oe low, tx_ready=1; on accept, latch tx_data, compute odd parity (~^tx_data), clear the bit counter, go to INHIBIT next cycle.
REQ-017 INHIBIT: k_clock_oe=1 and k_data_oe=0 for exactly INHIBIT_CYCLES cycles; in the final cycle assert k_data_oe=1, then go to START.
REQ-018 START: k_clock_oe=0 and k_data_oe=1 (start bit 0); on the first falling edge drive bit0, go to BITS.
REQ-019 BITS: on each falling edge advance to the next bit (bit1..bit7, then parity); k_data_oe = inverse of the current bit; after parity, the next falling edge releases data (stop bit 1) and goes to STOP.
REQ-020 STOP: data released; on the next falling edge sample synchronized k_data: 0 goes to ACK (ack good), 1 pulses tx_err and goes to RELEASE.
REQ-021 ACK: wait until the synchronized k_clock and k_data are both 1, then pulse tx_done and go to IDLE.
REQ-022 RELEASE: both oe low; wait until the synchronized k_clock and k_data are both 1, then go to IDLE (no second pulse).
REQ-023 Exactly 11 falling edges SHALL occur from START to the ack sample; the bit counter SHALL be 4 bits and SHALL never wrap inside a frame.
REQ-024 tx_valid outside IDLE SHALL be ignored; tx_data changes after accept SHALL NOT affect the frame in flight.
REQ-025 tx_done and tx_err SHALL never assert in the same cycle.

Reset
REQ-026 While rst_n=0: state IDLE, k_clock_oe=0, k_data_oe=0, tx_ready=1, tx_done=0, tx_err=0, all counters and synchronizers cleared (synchronizers to 1).
REQ-027 Reset mid-frame SHALL release both lines immediately (asynchronously) with no tx_done or tx_err pulse.

Configuration
REQ-028 Macro PS2_TX_TIMEOUT_EN defined: a watchdog SHALL count from leaving IDLE; reaching TIMEOUT_CYCLES in any non-IDLE state SHALL release both lines, pulse tx_err, and go to RELEASE.
REQ-029 PS2_TX_TIMEOUT_EN undefined: no watchdog logic; the block waits indefinitely for device clocks, and TIMEOUT_CYCLES is unused.

Verification
REQ-030 Send 8'hED, device model acks -> line data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once; tx_err stays 0.
REQ-031 Send 8'h01 -> parity bit 0 on the 10th falling edge; tx_done pulses once.
REQ-032 Device leaves data high at the ack edge -> tx_err pulses once, tx_done stays 0, return to IDLE after the lines go high.
REQ-033 Measure INHIBIT -> k_clock_oe high for exactly INHIBIT_CYCLES cycles; k_data_oe rises in its last cycle.
REQ-034 Assert rst_n=0 after the 5th falling edge -> both oe 0 immediately; tx_ready=1 after release; no pulses.
REQ-035 With PS2_TX_TIMEOUT_EN and the device silent after INHIBIT -> tx_err at TIMEOUT_CYCLES; without the macro -> block stays in START.
